mem_sync_arbiter: RTL and testbench
===================================

Name: mem_sync_arbiter

Overview:
Downstream consumer of the per-bank sync requests that drive the row-cache sync logic (MEMSyncTop).
- Collects one-cycle sync pulses from all banks and latches each bank's RowId, cached row index and transfer direction.
- Serialises the requests, round-robin, into a single valid/ready transfer port toward the backing-store mover.
- Returns a per-bank completion pulse when the mover reports done.

Parameters:
- BGWIDTH, 2, bank-group address width.
- BAWIDTH, 2, bank address width.
- CHWIDTH, 6, cached-row index width.
- ADDRWIDTH, 17, DRAM row address width.
- NB (localparam), 2**(BGWIDTH+BAWIDTH), total banks; bank index = bg*2**BAWIDTH + ba.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sync  in  NB  per-bank request pulse.
- sync_wr  in  NB  per-bank direction, sampled with sync: 1 = write-back (cache->store), 0 = fetch.
- row_id  in  NB*ADDRWIDTH  flattened per-bank RowId; bank i occupies bits [i*ADDRWIDTH +: ADDRWIDTH].
- crow_id  in  NB*CHWIDTH  flattened per-bank cached-row index; same slicing rule.
- xfer_valid  out  1  transfer request valid.
- xfer_ready  in  1  mover accepts the request.
- xfer_wr  out  1  direction of the current transfer.
- xfer_row  out  ADDRWIDTH  DRAM row of the current transfer.
- xfer_crow  out  CHWIDTH  cached row of the current transfer.
- xfer_bank  out  BGWIDTH+BAWIDTH  bank index of the current transfer.
- xfer_done  in  1  mover completion pulse.
- bank_done  out  NB  one-cycle completion pulse per bank.
- pending  out  NB  request outstanding (queued or in service).
- busy  out  1  FSM not IDLE.
- err_dup  out  1  sticky: a request was dropped.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Outputs: all outputs 0.
  - State: FSM=IDLE, round-robin pointer=0, all request slots cleared.
  - Reset mid-transfer: the in-flight transfer is abandoned; no bank_done pulse is issued.
- Capture:
  - sync[i]=1 with pending[i]=0: at that edge set pending[i] and latch sync_wr[i], the row_id slice and the crow_id slice into slot i.
  - sync[i]=1 with pending[i]=1: request dropped, slot unchanged, err_dup set. err_dup clears only on reset.
  - sync[i] in the same cycle that bank i's DONE clears it: the new request is accepted, with no error.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any registered pending bit is set and that bank is not the one being completed, select the first pending bank at or after the round-robin pointer (wrapping modulo NB). Copy its slot to the xfer_* registers and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: xfer_valid=1 and xfer_* held stable. When xfer_valid & xfer_ready, go to WAIT. xfer_valid drops the cycle after acceptance.
  - WAIT: on xfer_done go to DONE. xfer_done is ignored in every state except WAIT, including in the acceptance cycle.
  - DONE: bank_done[sel]=1 for exactly one cycle, pending[sel] cleared, pointer = (sel+1) mod NB, go to IDLE.
- Latency and throughput:
  - A sync sampled at edge k shows pending high after edge k and xfer_valid high after edge k+1.
  - With xfer_ready tied high and xfer_done returned the cycle after acceptance, back-to-back transfers occur at one per 4 cycles.
- Hold and update rules:
  - xfer_* outputs hold their last values in IDLE and change only on IDLE->ISSUE.
  - busy = (state != IDLE).
  - Bank index arithmetic is unsigned, with pointer wrap NB-1 -> 0.

Test Plan:
- Single request: reset, then sync bank 5 with row 0x1ABCD, crow 0x2A, wr=1. Required: xfer_valid 2 cycles later with xfer_bank=5, xfer_row=0x1ABCD, xfer_crow=0x2A, xfer_wr=1. Ready high, done the next cycle -> bank_done[5] pulses 1 cycle and pending[5]=0.
- Round robin: banks 3, 7 and 12 pulsed simultaneously with pointer 0. Required: serviced in order 3, 7, 12. Then re-pulse 3 and 7 with pointer 13 -> order 3, 7 via wrap.
- Backpressure: hold xfer_ready low 10 cycles. Required: xfer_valid held high and xfer_* stable throughout; acceptance only on the cycle ready rises.
- Duplicate request: re-pulse bank 2 while it is in WAIT. Required: err_dup=1 and stays 1; bank 2 transfers exactly once. A re-pulse on bank 2's DONE cycle is accepted, with err_dup unchanged.
- Stray done: pulse xfer_done in IDLE and in ISSUE. Required: no state change and no bank_done.
- Reset mid-transfer: assert reset_n low in WAIT. Required: all outputs 0 immediately (asynchronous), no bank_done. Post-reset, a fresh sync on bank 0 behaves as in the single-request case.

Source files
------------

// File: rtl/mem_sync_arbiter.sv
// Round-robin arbiter serialising per-bank row-cache sync requests onto one
// valid/ready transfer port, returning a one-cycle completion pulse per bank.
module mem_sync_arbiter #(
   parameter int unsigned BGWIDTH   = 2,
   parameter int unsigned BAWIDTH   = 2,
   parameter int unsigned CHWIDTH   = 6,
   parameter int unsigned ADDRWIDTH = 17,
   localparam int unsigned BW       = BGWIDTH + BAWIDTH,
   localparam int unsigned NB       = 2 ** BW
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NB-1:0]           sync,
   input  logic [NB-1:0]           sync_wr,
   input  logic [NB*ADDRWIDTH-1:0] row_id,
   input  logic [NB*CHWIDTH-1:0]   crow_id,
   output logic                    xfer_valid,
   input  logic                    xfer_ready,
   output logic                    xfer_wr,
   output logic [ADDRWIDTH-1:0]    xfer_row,
   output logic [CHWIDTH-1:0]      xfer_crow,
   output logic [BW-1:0]           xfer_bank,
   input  logic                    xfer_done,
   output logic [NB-1:0]           bank_done,
   output logic [NB-1:0]           pending,
   output logic                    busy,
   output logic                    err_dup
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   typedef struct packed {
      logic                 wr;
      logic [ADDRWIDTH-1:0] row;
      logic [CHWIDTH-1:0]   crow;
   } slot_t;

   state_t                state_q, state_d;
   slot_t [NB-1:0]        slot_q, slot_d;
   logic  [NB-1:0]        pending_q, pending_d;
   logic  [NB-1:0]        bank_done_q, bank_done_d;
   logic  [BW-1:0]        ptr_q, ptr_d;
   logic  [BW-1:0]        sel_q, sel_d;
   logic                  xfer_valid_q, xfer_valid_d;
   logic                  xfer_wr_q, xfer_wr_d;
   logic  [ADDRWIDTH-1:0] xfer_row_q, xfer_row_d;
   logic  [CHWIDTH-1:0]   xfer_crow_q, xfer_crow_d;
   logic                  busy_q, busy_d;
   logic                  err_dup_q, err_dup_d;

   logic                  found;
   logic  [BW-1:0]        pick;
   logic  [BW-1:0]        idx;
   logic  [NB-1:0]        clr;

   // First pending bank at or after the pointer; BW-bit add wraps modulo NB.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = ptr_q;
      for (int k = 0; k < NB; k++) begin
         idx = ptr_q + BW'(k);
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      pending_d   = pending_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      xfer_wr_d   = xfer_wr_q;
      xfer_row_d  = xfer_row_q;
      xfer_crow_d = xfer_crow_q;
      err_dup_d   = err_dup_q;
      clr         = '0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d     = S_ISSUE;
               sel_d       = pick;
               xfer_wr_d   = slot_q[pick].wr;
               xfer_row_d  = slot_q[pick].row;
               xfer_crow_d = slot_q[pick].crow;
            end
         end
         S_ISSUE: begin
            if (xfer_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (xfer_done) state_d = S_DONE;
         end
         S_DONE: begin
            clr[sel_q] = 1'b1;
            ptr_d      = sel_q + BW'(1);
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      pending_d = pending_q & ~clr;

      // A bank being retired this cycle may immediately re-request.
      for (int i = 0; i < NB; i++) begin
         if (sync[i]) begin
            if (pending_q[i] && !clr[i]) begin
               err_dup_d = 1'b1;
            end else begin
               pending_d[i]   = 1'b1;
               slot_d[i].wr   = sync_wr[i];
               slot_d[i].row  = row_id[i*ADDRWIDTH +: ADDRWIDTH];
               slot_d[i].crow = crow_id[i*CHWIDTH +: CHWIDTH];
            end
         end
      end

      xfer_valid_d = (state_d == S_ISSUE);
      busy_d       = (state_d != S_IDLE);
      bank_done_d  = '0;
      if (state_d == S_DONE) bank_done_d[sel_d] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         slot_q       <= '0;
         pending_q    <= '0;
         bank_done_q  <= '0;
         ptr_q        <= '0;
         sel_q        <= '0;
         xfer_valid_q <= 1'b0;
         xfer_wr_q    <= 1'b0;
         xfer_row_q   <= '0;
         xfer_crow_q  <= '0;
         busy_q       <= 1'b0;
         err_dup_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         pending_q    <= pending_d;
         bank_done_q  <= bank_done_d;
         ptr_q        <= ptr_d;
         sel_q        <= sel_d;
         xfer_valid_q <= xfer_valid_d;
         xfer_wr_q    <= xfer_wr_d;
         xfer_row_q   <= xfer_row_d;
         xfer_crow_q  <= xfer_crow_d;
         busy_q       <= busy_d;
         err_dup_q    <= err_dup_d;
      end
   end

   assign xfer_valid = xfer_valid_q;
   assign xfer_wr    = xfer_wr_q;
   assign xfer_row   = xfer_row_q;
   assign xfer_crow  = xfer_crow_q;
   assign xfer_bank  = sel_q;
   assign bank_done  = bank_done_q;
   assign pending    = pending_q;
   assign busy       = busy_q;
   assign err_dup    = err_dup_q;

endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Directed bench for mem_sync_arbiter: latency, round robin with wrap,
// backpressure, duplicate requests, stray done pulses and mid-transfer reset.
module tb_mem_sync_arbiter;

   localparam int unsigned BW = 4;
   localparam int unsigned NB = 16;
   localparam int unsigned AW = 17;
   localparam int unsigned CW = 6;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NB-1:0]    sync;
   logic [NB-1:0]    sync_wr;
   logic [NB*AW-1:0] row_id;
   logic [NB*CW-1:0] crow_id;
   logic             xfer_valid;
   logic             xfer_ready;
   logic             xfer_wr;
   logic [AW-1:0]    xfer_row;
   logic [CW-1:0]    xfer_crow;
   logic [BW-1:0]    xfer_bank;
   logic             xfer_done;
   logic [NB-1:0]    bank_done;
   logic [NB-1:0]    pending;
   logic             busy;
   logic             err_dup;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_sync_arbiter #(
      .BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(CW), .ADDRWIDTH(AW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sync(sync), .sync_wr(sync_wr),
      .row_id(row_id), .crow_id(crow_id), .xfer_valid(xfer_valid),
      .xfer_ready(xfer_ready), .xfer_wr(xfer_wr), .xfer_row(xfer_row),
      .xfer_crow(xfer_crow), .xfer_bank(xfer_bank), .xfer_done(xfer_done),
      .bank_done(bank_done), .pending(pending), .busy(busy), .err_dup(err_dup)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int b, input logic wr, input logic [AW-1:0] row,
                          input logic [CW-1:0] crow);
      sync[b]              = 1'b1;
      sync_wr[b]           = wr;
      row_id[b*AW +: AW]   = row;
      crow_id[b*CW +: CW]  = crow;
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (xfer_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, " valid"}, 32'(xfer_valid), 32'd1);
   endtask

   // Full transfer with ready high on issue and done one cycle after acceptance.
   task automatic serve(input string tag, input int b, input logic wr,
                        input logic [AW-1:0] row, input logic [CW-1:0] crow,
                        output int n);
      wait_valid(tag, n);
      chk({tag, " bank"}, 32'(xfer_bank), 32'(b));
      chk({tag, " row"},  32'(xfer_row),  32'(row));
      chk({tag, " crow"}, 32'(xfer_crow), 32'(crow));
      chk({tag, " wr"},   32'(xfer_wr),   32'(wr));
      xfer_ready = 1'b1;
      tick();
      xfer_ready = 1'b0;
      chk({tag, " valid_drop"}, 32'(xfer_valid), 32'd0);
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      chk({tag, " bank_done"}, 32'(bank_done), 32'd1 << b);
      tick();
      chk({tag, " done_clr"}, 32'(bank_done), 32'd0);
      chk({tag, " pend_clr"}, 32'(pending[b]), 32'd0);
   endtask

   initial begin
      int n;
      logic [AW-1:0] hold_row;
      logic [BW-1:0] hold_bank;

      reset_n    = 1'b0;
      sync       = '0;
      sync_wr    = '0;
      row_id     = '0;
      crow_id    = '0;
      xfer_ready = 1'b0;
      xfer_done  = 1'b0;
      tick();
      tick();
      chk("rst valid",   32'(xfer_valid), 32'd0);
      chk("rst pending", 32'(pending),    32'd0);
      chk("rst busy",    32'(busy),       32'd0);
      chk("rst err",     32'(err_dup),    32'd0);
      chk("rst row",     32'(xfer_row),   32'd0);
      reset_n = 1'b1;
      tick();

      // Single request, bank 5
      set_req(5, 1'b1, 17'h1ABCD, 6'h2A);
      tick();
      sync = '0;
      chk("t1 pending",     32'(pending),    32'h0020);
      chk("t1 valid_early", 32'(xfer_valid), 32'd0);
      tick();
      chk("t1 valid_lat",   32'(xfer_valid), 32'd1);
      serve("t1", 5, 1'b1, 17'h1ABCD, 6'h2A, n);
      chk("t1 busy", 32'(busy), 32'd0);

      // Bank 15 moves the pointer from 15 to 0
      set_req(15, 1'b0, 17'h0000F, 6'h0F);
      tick();
      sync = '0;
      serve("t15", 15, 1'b0, 17'h0000F, 6'h0F, n);

      // Round robin from pointer 0, one transfer per 4 cycles
      set_req(3,  1'b1, 17'h00333, 6'h03);
      set_req(7,  1'b0, 17'h07777, 6'h07);
      set_req(12, 1'b1, 17'h1CCCC, 6'h0C);
      tick();
      sync = '0;
      chk("rr pending", 32'(pending), 32'h1088);
      serve("rr3", 3, 1'b1, 17'h00333, 6'h03, n);
      chk("rr3 gap", 32'(n), 32'd1);
      serve("rr7", 7, 1'b0, 17'h07777, 6'h07, n);
      chk("rr7 gap", 32'(n), 32'd1);
      serve("rr12", 12, 1'b1, 17'h1CCCC, 6'h0C, n);
      chk("rr12 gap", 32'(n), 32'd1);

      // Pointer now 13: 3 then 7 through the wrap
      set_req(3, 1'b0, 17'h13131, 6'h13);
      set_req(7, 1'b1, 17'h17171, 6'h17);
      tick();
      sync = '0;
      serve("wr3", 3, 1'b0, 17'h13131, 6'h13, n);
      serve("wr7", 7, 1'b1, 17'h17171, 6'h17, n);

      // Backpressure on bank 9
      set_req(9, 1'b1, 17'h09999, 6'h29);
      tick();
      sync = '0;
      wait_valid("bp", n);
      hold_row  = xfer_row;
      hold_bank = xfer_bank;
      chk("bp bank0", 32'(hold_bank), 32'd9);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("bp hold valid", 32'(xfer_valid), 32'd1);
         chk("bp hold row",   32'(xfer_row),   32'(hold_row));
         chk("bp hold bank",  32'(xfer_bank),  32'(hold_bank));
      end
      serve("bp", 9, 1'b1, 17'h09999, 6'h29, n);

      // Duplicate on bank 2 while in WAIT, then re-request in its DONE cycle
      set_req(2, 1'b1, 17'h12345, 6'h15);
      tick();
      sync = '0;
      wait_valid("dup", n);
      chk("dup bank", 32'(xfer_bank), 32'd2);
      xfer_ready = 1'b1;
      tick();
      xfer_ready = 1'b0;
      set_req(2, 1'b0, 17'h0DEAD, 6'h3F);
      tick();
      sync = '0;
      chk("dup err",     32'(err_dup),  32'd1);
      chk("dup pending", 32'(pending),  32'h0004);
      chk("dup row",     32'(xfer_row), 32'h12345);
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      chk("dup bank_done", 32'(bank_done), 32'h0004);
      set_req(2, 1'b0, 17'h00111, 6'h11);
      tick();
      sync = '0;
      chk("redo done_clr", 32'(bank_done), 32'd0);
      chk("redo pending",  32'(pending),   32'h0004);
      chk("redo err",      32'(err_dup),   32'd1);
      serve("redo", 2, 1'b0, 17'h00111, 6'h11, n);
      chk("redo err_hold", 32'(err_dup), 32'd1);
      chk("redo idle",     32'(pending), 32'd0);

      // Stray done in IDLE
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      chk("stray idle busy",  32'(busy),       32'd0);
      chk("stray idle done",  32'(bank_done),  32'd0);
      chk("stray idle valid", 32'(xfer_valid), 32'd0);

      // Stray done in ISSUE and in the acceptance cycle
      set_req(4, 1'b1, 17'h04444, 6'h04);
      tick();
      sync = '0;
      tick();
      chk("stray issue valid0", 32'(xfer_valid), 32'd1);
      xfer_done = 1'b1;
      tick();
      chk("stray issue valid", 32'(xfer_valid), 32'd1);
      chk("stray issue done",  32'(bank_done),  32'd0);
      xfer_ready = 1'b1;
      tick();
      xfer_ready = 1'b0;
      xfer_done  = 1'b0;
      chk("stray acc valid", 32'(xfer_valid), 32'd0);
      chk("stray acc busy",  32'(busy),       32'd1);
      tick();
      chk("stray wait done", 32'(bank_done), 32'd0);
      chk("stray wait busy", 32'(busy),      32'd1);
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      chk("stray bank_done", 32'(bank_done), 32'h0010);
      tick();
      chk("stray end busy",  32'(busy),      32'd0);

      // Reset while in WAIT
      set_req(6, 1'b1, 17'h06666, 6'h06);
      tick();
      sync = '0;
      wait_valid("rmid", n);
      xfer_ready = 1'b1;
      tick();
      xfer_ready = 1'b0;
      chk("rmid busy", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rmid valid", 32'(xfer_valid), 32'd0);
      chk("rmid busy0", 32'(busy),       32'd0);
      chk("rmid pend",  32'(pending),    32'd0);
      chk("rmid done",  32'(bank_done),  32'd0);
      chk("rmid err",   32'(err_dup),    32'd0);
      chk("rmid row",   32'(xfer_row),   32'd0);
      chk("rmid bank",  32'(xfer_bank),  32'd0);
      chk("rmid crow",  32'(xfer_crow),  32'd0);
      chk("rmid wr",    32'(xfer_wr),    32'd0);
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      chk("rmid done_rst", 32'(bank_done), 32'd0);
      reset_n = 1'b1;
      tick();
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      chk("post stray done", 32'(bank_done), 32'd0);
      chk("post stray busy", 32'(busy),      32'd0);

      // Fresh request on bank 0 after reset
      set_req(0, 1'b0, 17'h00F0F, 6'h3C);
      tick();
      sync = '0;
      chk("post pending",     32'(pending),    32'h0001);
      chk("post valid_early", 32'(xfer_valid), 32'd0);
      tick();
      chk("post valid_lat",   32'(xfer_valid), 32'd1);
      serve("post", 0, 1'b0, 17'h00F0F, 6'h3C, n);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
